// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses a combinational instruction memory and
// registers the fetched word into IF/ID, with stall, redirect/flush and early JUMP resolution.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int unsigned IMEM_DEPTH  = 32,
  parameter logic [5:0]  JUMP_OPCODE = 6'h15,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic        ifid_valid_o,
  output logic        pc_oob_o,
  output logic [31:0] instr_count_o
);

  localparam logic [31:0] DepthW = 32'(IMEM_DEPTH);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;
  logic        r_ifid_valid;
  logic [31:0] r_count;

  logic [31:0] w_pc_d;
  logic [31:0] w_ifid_instr_d;
  logic [31:0] w_ifid_pc_d;
  logic        w_ifid_valid_d;
  logic [31:0] w_count_d;
  logic        w_oob;
  logic        w_is_jump;

  assign w_oob     = (r_pc >= DepthW);
  assign w_is_jump = (imem_data_i[31:26] == JUMP_OPCODE);

  always_comb begin
    w_pc_d         = r_pc;
    w_ifid_instr_d = r_ifid_instr;
    w_ifid_pc_d    = r_ifid_pc;
    w_ifid_valid_d = r_ifid_valid;
    w_count_d      = r_count;
    if (redirect_i) begin
      // Flush must win over stall, and discards any JUMP fetched this cycle.
      w_pc_d         = redirect_pc_i;
      w_ifid_instr_d = NOP_WORD;
      w_ifid_valid_d = 1'b0;
    end else if (stall_i) begin
      w_pc_d = r_pc;
    end else if (w_oob) begin
      w_ifid_instr_d = NOP_WORD;
      w_ifid_valid_d = 1'b0;
    end else begin
      w_ifid_instr_d = imem_data_i;
      w_ifid_pc_d    = r_pc;
      w_ifid_valid_d = 1'b1;
      w_count_d      = r_count + 32'd1;
      w_pc_d         = w_is_jump ? {16'b0, imem_data_i[15:0]} : r_pc + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc    <= 32'd0;
      r_ifid_valid <= 1'b0;
      r_count      <= 32'd0;
    end else begin
      r_pc         <= w_pc_d;
      r_ifid_instr <= w_ifid_instr_d;
      r_ifid_pc    <= w_ifid_pc_d;
      r_ifid_valid <= w_ifid_valid_d;
      r_count      <= w_count_d;
    end
  end

  assign imem_addr_o   = r_pc;
  assign ifid_instr_o  = r_ifid_instr;
  assign ifid_pc_o     = r_ifid_pc;
  assign ifid_valid_o  = r_ifid_valid;
  assign pc_oob_o      = w_oob;
  assign instr_count_o = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected post-edge state,
// a monitor pops and compares on the falling edge (or on demand for async reset).
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic        ifid_valid_o;
  logic        pc_oob_o;
  logic [31:0] instr_count_o;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_valid_o  (ifid_valid_o),
    .pc_oob_o      (pc_oob_o),
    .instr_count_o (instr_count_o)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:31];
  assign imem_data_i = (imem_addr_o < 32'd32) ? mem[imem_addr_o[4:0]] : 32'hdead_beef;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        oob;
    logic [31:0] cnt;
    logic        pc_care;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  event        chk_now;
  logic [31:0] cur_pc;
  logic [31:0] cur_cnt;

  task automatic push(input string name, input logic [31:0] a, input logic [31:0] i,
                      input logic [31:0] p, input logic v, input logic o,
                      input logic [31:0] c, input logic pc_care);
    exp_t e;
    e.name = name; e.addr = a; e.instr = i; e.pc = p;
    e.valid = v; e.oob = o; e.cnt = c; e.pc_care = pc_care;
    sb.push_back(e);
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    forever begin
      @(negedge clk or chk_now);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (imem_addr_o !== e.addr || ifid_instr_o !== e.instr ||
            (e.pc_care && ifid_pc_o !== e.pc) || ifid_valid_o !== e.valid ||
            pc_oob_o !== e.oob || instr_count_o !== e.cnt) begin
          errors++;
          $display("FAIL %s: got addr=%0d instr=%h pc=%0d v=%b oob=%b cnt=%0d exp addr=%0d instr=%h pc=%0d(care=%b) v=%b oob=%b cnt=%0d",
                   e.name, imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, pc_oob_o,
                   instr_count_o, e.addr, e.instr, e.pc, e.pc_care, e.valid, e.oob, e.cnt);
        end
      end
    end
  end

  task automatic cyc(input string name, input logic s, input logic r, input logic [31:0] rp,
                     input logic [31:0] a, input logic [31:0] i, input logic [31:0] p,
                     input logic v, input logic o, input logic [31:0] c, input logic pc_care);
    stall_i = s; redirect_i = r; redirect_pc_i = rp;
    @(posedge clk);
    #1;
    push(name, a, i, p, v, o, c, pc_care);
    stall_i = 1'b0; redirect_i = 1'b0;
  endtask

  // Unstalled sequential fetches (no JUMP words on the path).
  task automatic seq_run(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(name, 1'b0, 1'b0, 32'd0, cur_pc + 32'd1, mem[cur_pc[4:0]], cur_pc, 1'b1,
          (cur_pc + 32'd1 >= 32'd32), cur_cnt + 32'd1, 1'b1);
      cur_pc  = cur_pc + 32'd1;
      cur_cnt = cur_cnt + 32'd1;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0400_0000 | 32'(i);
    mem[0]  = 32'h1001_0064;
    mem[1]  = 32'h4c1e_0001;
    mem[2]  = 32'h0000_0000;
    mem[15] = 32'h5400_0015;

    #2;
    push("reset", 32'd0, Nop, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    ->chk_now;
    #1 rst_n = 1'b1;

    cur_pc = 0; cur_cnt = 0;
    seq_run("seq_start", 4);
    for (int k = 0; k < 3; k++)
      cyc("stall_hold", 1'b1, 1'b0, 32'd0, 32'd4, mem[3], 32'd3, 1'b1, 1'b0, 32'd4, 1'b1);
    seq_run("stall_resume", 7);

    cyc("redirect_over_stall", 1'b1, 1'b1, 32'd16, 32'd16, Nop, 32'd0, 1'b0, 1'b0, 32'd11,
        1'b0);
    cur_pc = 16;
    seq_run("seq_to_oob", 16);
    for (int k = 0; k < 3; k++)
      cyc("oob_hold", 1'b0, 1'b0, 32'd0, 32'd32, Nop, 32'd31, 1'b0, 1'b1, 32'd27, 1'b1);
    cyc("oob_redirect", 1'b0, 1'b1, 32'd5, 32'd5, Nop, 32'd0, 1'b0, 1'b0, 32'd27, 1'b0);
    cur_pc = 5;
    seq_run("seq_after_oob", 10);

    cyc("jump", 1'b0, 1'b0, 32'd0, 32'd21, 32'h5400_0015, 32'd15, 1'b1, 1'b0, 32'd38, 1'b1);
    cur_pc = 21; cur_cnt = 38;
    seq_run("jump_target", 1);

    mem[22] = 32'h5400_0016;
    cyc("self_jump1", 1'b0, 1'b0, 32'd0, 32'd22, mem[22], 32'd22, 1'b1, 1'b0, 32'd40, 1'b1);
    cyc("self_jump2", 1'b0, 1'b0, 32'd0, 32'd22, mem[22], 32'd22, 1'b1, 1'b0, 32'd41, 1'b1);
    cyc("redirect_beats_jump", 1'b0, 1'b1, 32'd8, 32'd8, Nop, 32'd0, 1'b0, 1'b0, 32'd41,
        1'b0);
    cur_pc = 8; cur_cnt = 41;
    seq_run("pre_reset", 1);

    // Asynchronous reset pulse between edges at PC 9.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    push("async_reset", 32'd0, Nop, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    ->chk_now;
    @(posedge clk);
    #1 push("reset_hold", 32'd0, Nop, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cur_pc = 0; cur_cnt = 0;
    seq_run("restart", 3);

    mem[23] = 32'h5400_0028;
    cyc("redirect_23", 1'b0, 1'b1, 32'd23, 32'd23, Nop, 32'd0, 1'b0, 1'b0, 32'd3, 1'b0);
    cyc("jump_oob_target", 1'b0, 1'b0, 32'd0, 32'd40, 32'h5400_0028, 32'd23, 1'b1, 1'b1,
        32'd4, 1'b1);
    cyc("jump_oob_hold", 1'b0, 1'b0, 32'd0, 32'd40, Nop, 32'd23, 1'b0, 1'b1, 32'd4, 1'b1);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
